// File: rtl/seq_det_pkg.sv
// Shared constants and KMP helper functions for the dual serial pattern detector.
// Patterns are stored MSB-first: bit index 0 of a pattern is its MSB.
package seq_det_pkg;

  localparam int         LEN_DEFAULT = 5;
  localparam logic [4:0] PAT_10001   = 5'b10001;
  localparam logic [4:0] PAT_10101   = 5'b10101;

  // Bit i of a len-bit pattern, counting from the first-received bit.
  function automatic logic pat_bit(input logic [7:0] pattern, input int len, input int i);
    return pattern[3'(len - 1 - i)];
  endfunction

  // Longest proper prefix of pattern[0..k-1] that is also a suffix of it.
  function automatic int fail_link(input logic [7:0] pattern, input int len, input int k);
    int   res;
    logic ok;
    res = 0;
    for (int b = 1; b < 8; b++) begin
      if (b < k) begin
        ok = 1'b1;
        for (int j = 0; j < 8; j++)
          if (j < b && pat_bit(pattern, len, j) != pat_bit(pattern, len, k - b + j))
            ok = 1'b0;
        if (ok) res = b;
      end
    end
    return res;
  endfunction

  // Prefix length after seeing bit b in state k (returns len on a full match).
  function automatic int kmp_next(input logic [7:0] pattern, input int len,
                                  input int k, input logic b);
    int s;
    s = k;
    for (int it = 0; it < 8; it++)
      if (s > 0 && pat_bit(pattern, len, s) != b)
        s = fail_link(pattern, len, s);
    return (pat_bit(pattern, len, s) == b) ? s + 1 : 0;
  endfunction

endpackage

// File: rtl/seq_det_core.sv
// Single-pattern serial detector: KMP prefix-length FSM with a registered pulse.
// SEQ_DET_OVERLAP_EN: after a match, restart from the pattern's failure link
// instead of IDLE, so overlapping occurrences are reported.
module seq_det_core
  import seq_det_pkg::*;
#(
  parameter int             LEN     = 5,
  parameter logic [LEN-1:0] PATTERN = 5'b10001
) (
  input  logic clock,
  input  logic reset,
  input  logic data,
  output logic detected
);

  localparam int             SW    = $clog2(LEN);
  localparam int             NST   = 2 ** SW;
  localparam logic [7:0]     PAT8  = 8'(PATTERN);
  localparam logic [SW-1:0]  LAST  = SW'(LEN - 1);
`ifdef SEQ_DET_OVERLAP_EN
  localparam logic [SW-1:0]  RESTART = SW'(fail_link(PAT8, LEN, LEN));
`else
  localparam logic [SW-1:0]  RESTART = '0;
`endif

  logic [SW-1:0]          state, state_nxt;
  logic                   match;
  logic [NST-1:0][SW-1:0] nxt0, nxt1;

  // Transition tables built from PATTERN at elaboration; unreachable
  // encodings fall back to IDLE.
  for (genvar k = 0; k < NST; k++) begin : g_tbl
    localparam int N0 = (k < LEN) ? kmp_next(PAT8, LEN, k, 1'b0) : 0;
    localparam int N1 = (k < LEN) ? kmp_next(PAT8, LEN, k, 1'b1) : 0;
    assign nxt0[k] = (N0 < LEN) ? SW'(N0) : '0;
    assign nxt1[k] = (N1 < LEN) ? SW'(N1) : '0;
  end

  // Next prefix length and full-match detection.
  always_comb begin
    match     = 1'b0;
    state_nxt = data ? nxt1[state] : nxt0[state];
    if (state == LAST && data == PATTERN[0]) begin
      match     = 1'b1;
      state_nxt = RESTART;
    end
  end

  // State register and registered detect pulse.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= '0;
      detected <= 1'b0;
    end else begin
      state    <= state_nxt;
      detected <= match;
    end
  end

endmodule

// File: rtl/seq_det_dual.sv
// Two independent serial pattern detectors sharing one data input.
// Optional build macro: SEQ_DET_OVERLAP_EN (overlapping detection).
module seq_det_dual
  import seq_det_pkg::*;
#(
  parameter int             LEN   = LEN_DEFAULT,
  parameter logic [LEN-1:0] PAT_A = LEN'(PAT_10001),
  parameter logic [LEN-1:0] PAT_B = LEN'(PAT_10101)
) (
  input  logic clock,
  input  logic reset,
  input  logic data,
  output logic detected_10001,
  output logic detected_10101
);

  seq_det_core #(.LEN(LEN), .PATTERN(PAT_A)) u_det_a (
    .clock    (clock),
    .reset    (reset),
    .data     (data),
    .detected (detected_10001)
  );

  seq_det_core #(.LEN(LEN), .PATTERN(PAT_B)) u_det_b (
    .clock    (clock),
    .reset    (reset),
    .data     (data),
    .detected (detected_10101)
  );

endmodule

// File: tb/tb_seq_det_dual.sv
// Scoreboard bench for seq_det_dual: a reference model (last LEN bits equal the
// pattern, plus the LEN-bit guard when overlap is disabled) pushes expected
// outputs per driven bit; they are popped and compared after the clock edge.
module tb_seq_det_dual;

  localparam int         LEN = 5;
  localparam logic [4:0] PA  = 5'b10001;
  localparam logic [4:0] PB  = 5'b10101;
`ifdef SEQ_DET_OVERLAP_EN
  localparam bit OVL = 1'b1;
`else
  localparam bit OVL = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic data  = 1'b0;
  logic detected_10001, detected_10101;

  seq_det_dual dut (
    .clock          (clock),
    .reset          (reset),
    .data           (data),
    .detected_10001 (detected_10001),
    .detected_10101 (detected_10101)
  );

  always #5 clock = ~clock;

  typedef struct packed { logic a; logic b; } exp_t;

  exp_t       sb[$];
  int         n_chk = 0, n_pass = 0;
  logic [7:0] hist;
  int         cnt_a, cnt_b, pulses_a, pulses_b;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic model_reset();
    hist  = '0;
    cnt_a = 0;
    cnt_b = 0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    model_reset();
    sb.delete();
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
  endtask

  // Drive one bit at a negedge, predict, then compare at the next negedge.
  task automatic send_bit(input logic b);
    exp_t e, o;
    data  = b;
    hist  = {hist[6:0], b};
    cnt_a = (cnt_a < LEN) ? cnt_a + 1 : cnt_a;
    cnt_b = (cnt_b < LEN) ? cnt_b + 1 : cnt_b;
    e.a   = (hist[4:0] == PA) && (cnt_a >= LEN);
    e.b   = (hist[4:0] == PB) && (cnt_b >= LEN);
    if (e.a && !OVL) cnt_a = 0;
    if (e.b && !OVL) cnt_b = 0;
    sb.push_back(e);
    @(posedge clock);
    @(negedge clock);
    if (sb.size() == 0) begin
      chk("sb_underflow", 32'd1, 32'd0);
    end else begin
      o = sb.pop_front();
      chk("det_10001", {31'd0, detected_10001}, {31'd0, o.a});
      chk("det_10101", {31'd0, detected_10101}, {31'd0, o.b});
    end
    pulses_a += int'(detected_10001);
    pulses_b += int'(detected_10101);
  endtask

  // Send the low n bits of v, most significant first.
  task automatic send_vec(input logic [31:0] v, input int n);
    logic [31:0] t;
    for (int i = 0; i < n; i++) begin
      t = v >> (n - 1 - i);
      send_bit(t[0]);
    end
  endtask

  initial begin
    pulses_a = 0;
    pulses_b = 0;
    model_reset();

    // Reset held with data toggling: outputs stay low.
    @(negedge clock);
    for (int i = 0; i < 3; i++) begin
      data = ~data;
      @(negedge clock);
      chk("rst_hold_a", {31'd0, detected_10001}, 32'd0);
      chk("rst_hold_b", {31'd0, detected_10101}, 32'd0);
    end
    reset = 1'b1;

    // Async reset while a pulse is high drops it immediately.
    send_vec(32'b10101, 5);
    #1 reset = 1'b0;
    #1 chk("rst_async_b", {31'd0, detected_10101}, 32'd0);
    model_reset();
    @(negedge clock);
    reset = 1'b1;

    // Mid-sequence reset discards the partial 100 prefix.
    send_vec(32'b100, 3);
    #1 reset = 1'b0;
    #1 chk("rst_mid_a", {31'd0, detected_10001}, 32'd0);
    model_reset();
    @(negedge clock);
    reset = 1'b1;
    pulses_a = 0;
    send_vec(32'b01, 2);
    chk("rst_no_resume", pulses_a, 32'd0);

    // Mixed stream.
    do_reset();
    pulses_a = 0; pulses_b = 0;
    send_vec(32'b0101_0101_0111_0001_0001, 20);
    chk("mix_cnt_10101", pulses_b, OVL ? 32'd3 : 32'd1);
    chk("mix_cnt_10001", pulses_a, OVL ? 32'd2 : 32'd1);

    // Fallback re-uses the 10 prefix.
    do_reset();
    pulses_a = 0; pulses_b = 0;
    send_vec(32'b1010001, 7);
    chk("fb_cnt_10001", pulses_a, 32'd1);
    chk("fb_cnt_10101", pulses_b, 32'd0);

    // Back-to-back matches.
    do_reset();
    pulses_a = 0; pulses_b = 0;
    send_vec(32'b10101_10101, 10);
    chk("b2b_cnt_10101", pulses_b, 32'd2);

    // Constant streams never match.
    do_reset();
    pulses_a = 0; pulses_b = 0;
    send_vec(32'h0, 20);
    send_vec(32'hFFFFF, 20);
    chk("const_cnt_10001", pulses_a, 32'd0);
    chk("const_cnt_10101", pulses_b, 32'd0);

    // Random stream against the model.
    do_reset();
    for (int i = 0; i < 300; i++) send_bit(1'(($urandom_range(0, 9) < 6) ? 1 : 0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/seq_det_dual.md
Name: seq_det_dual

Overview:
- Serial-bitstream detector for two fixed 5-bit patterns, 10001 and 10101, from a single shared data input.
- Non-overlapping: a bit that completes a match is never reused as part of the next match of the same pattern.
- Each pattern has its own independent detector and its own one-cycle registered detect pulse.
- Sits on a serial data line as a frame-marker or pattern-flag generator for downstream control logic.

Parameters:
- LEN, 5, pattern length in bits (legal range 2..8).
- PAT_A, 5'b10001, pattern reported on detected_10001; MSB is received first.
- PAT_B, 5'b10101, pattern reported on detected_10101; MSB is received first.

Ports:
- clock  input  1  system clock; all sampling on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- data  input  1  serial data bit, sampled on every rising edge of clock.
- detected_10001  output  1  one-cycle pulse when PAT_A completes.
- detected_10101  output  1  one-cycle pulse when PAT_B completes.

Behaviour:
- Reset (reset=0, asynchronous):
  - Both detectors return to IDLE (matched prefix length 0); history and guard state are cleared.
  - Both outputs are forced to 0 immediately.
  - No partial match survives a reset, including a reset asserted mid-sequence.
- Per detector, state = longest matched prefix length k, 0..LEN-1 (IDLE = 0). On each rising edge, with b = sampled data:
  - If b equals pattern bit k and k < LEN-1: go to k+1.
  - If b equals pattern bit k and k = LEN-1: full match. Assert detect on the registered output for exactly the next cycle and go to IDLE (non-overlap).
  - Otherwise (mismatch): fall back to the longest proper prefix of the pattern that is a suffix of the received bits since the last IDLE entry (KMP failure rule), possibly 0.
- Equivalent reference definition for the verifier:
  - Detect fires at bit i iff the last LEN sampled bits equal the pattern, and
  - at least LEN bits have been sampled since the previous detect of that same pattern (or since reset).
- Output timing: registered. A match completing on edge n gives the output high from edge n until edge n+1, then low again.
- The two outputs are never asserted in consecutive cycles for the same pattern.
- The two detectors are fully independent. Both may fire on the same edge only if the patterns permit; with the default patterns this cannot happen.
- The fallback tables are derived from PAT_A/PAT_B at elaboration (a generate or function); they are not hand-coded.
- Back-to-back matches: the earliest possible second match is LEN bits after the first.
- No enable input; every rising edge samples data.

Optional Feature:
- Macro: SEQ_DET_OVERLAP_EN.
- Defined: overlapping detection.
  - After a full match, the state goes to the failure-link state of the complete pattern instead of IDLE; the guard in the reference definition is removed.
  - Examples: 10101 followed by 01 fires again; 10001 followed by 0001 fires again.
- Undefined (default): non-overlapping, as in Behaviour.

Decomposition:
- Package seq_det_pkg holds:
  - localparams LEN_DEFAULT=5, PAT_10001=5'b10001, PAT_10101=5'b10101;
  - function fail_link(pattern, k) returning the KMP fallback length.
- One sub-module: seq_det_core.
  - Parameters LEN and PATTERN; ports clock, reset, data, detected.
  - Instantiated twice in seq_det_dual.

Test Plan:
- Reset: hold reset=0 with data toggling for 3 cycles -> both outputs 0 throughout. Release, then send 1,0,0 and assert reset=0 -> outputs drop immediately. A following 0,1 must not complete a 10001.
- Mixed stream, one bit per cycle after reset: 0,1,0,1,0,1,0,1,0,1,1,1,0,0,0,1,0,0,0,1.
  - detected_10101 pulses once, the cycle after bit index 5; it does not fire at indices 7 or 9.
  - detected_10001 pulses once, after index 15; it does not fire at index 19.
- Same stream with SEQ_DET_OVERLAP_EN defined:
  - detected_10101 pulses after indices 5, 7 and 9.
  - detected_10001 pulses after indices 15 and 19.
- Fallback: stream 1,0,1,0,0,0,1 -> detected_10001 pulses after the last bit (prefix 10 re-used via fallback); detected_10101 stays 0.
- Back-to-back non-overlapping: 1,0,1,0,1,1,0,1,0,1 -> detected_10101 pulses after bits 4 and 9, each exactly one cycle wide.
- All-zeros for 20 cycles, then all-ones for 20 cycles -> both outputs stay 0.
